// File: rtl/eth_stats_pkg.sv
// rtl/eth_stats_pkg.sv - shared types and constants for the eth_stats AXI-Lite slave
package eth_stats_pkg;

    // Read channel: address accept, register select, data return.
    typedef enum logic [1:0] {
        RD_AR     = 2'd0,
        RD_SELECT = 2'd1,
        RD_R      = 2'd2
    } rd_state_t;

    // Write channel: collect AW/W, commit for one cycle, then hold the response.
    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_EXEC  = 2'd1,
        WR_BRESP = 2'd2
    } wr_state_t;

    // Register byte offsets.
    localparam int unsigned REG_ID       = 32'h0;
    localparam int unsigned REG_CTRL     = 32'h4;
    localparam int unsigned REG_STATUS   = 32'h8;
    localparam int unsigned REG_CNT_BASE = 32'hC;

    // CTRL bit positions.
    localparam int CTRL_FREEZE_BIT = 0;
    localparam int CTRL_SNAP_BIT   = 1;
    localparam int CTRL_CLEAR_BIT  = 2;

    // AXI response codes.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/eth_stats_shadow.sv
// rtl/eth_stats_shadow.sv - snapshot bank holding a frozen copy of all counters
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture d into the bank this cycle
//   d        : live counters, counter i at [i*CNT_W +: CNT_W]
//   q        : held copy, same layout as d
module eth_stats_shadow
    import eth_stats_pkg::*;
#(
    parameter int NUM_CNT = 3,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [NUM_CNT*CNT_W-1:0] d,
    output logic [NUM_CNT*CNT_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/eth_stats_axilite.sv
// rtl/eth_stats_axilite.sv - AXI4-Lite slave for datapath packet counters with freeze/snapshot/clear
//   clk, rst       : clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*: write address, data and response channels
//   s_axi_ar*/r*   : read address and data channels
//   cnt_in         : live counters, counter i at [i*CNT_W +: CNT_W]
//   cnt_clear      : one-cycle request to zero the datapath counters
//   frozen         : current CTRL.freeze
module eth_stats_axilite
    import eth_stats_pkg::*;
#(
    parameter int          ADDR_W   = 14,
    parameter int          NUM_CNT  = 3,
    parameter int          CNT_W    = 32,
    parameter logic [31:0] ID_VALUE = 32'h00E7_0001
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [ADDR_W-1:0]        s_axi_awaddr,
    input  logic [2:0]               s_axi_awprot,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    output logic [1:0]               s_axi_bresp,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    input  logic [ADDR_W-1:0]        s_axi_araddr,
    input  logic [2:0]               s_axi_arprot,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
    output logic                     cnt_clear,
    output logic                     frozen
);

    localparam logic [ADDR_W-1:0] A_ID       = ADDR_W'(REG_ID);
    localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(REG_CTRL);
    localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(REG_STATUS);
    localparam logic [ADDR_W-1:0] A_CNT_BASE = ADDR_W'(REG_CNT_BASE);
    localparam logic [ADDR_W-1:0] A_CNT_END  = ADDR_W'(REG_CNT_BASE + 4 * NUM_CNT);

    // Protection bits and the upper write data/strobe bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_wdata[31:3], s_axi_wstrb[3:1]};

    // ------------------------------------------------------------------
    // Control state and shadow bank
    // ------------------------------------------------------------------
    logic                     ctrl_freeze;
    logic                     shadow_load;
    logic [NUM_CNT*CNT_W-1:0] shadow_q;

    eth_stats_shadow #(
        .NUM_CNT (NUM_CNT),
        .CNT_W   (CNT_W)
    ) u_shadow (
        .clk  (clk),
        .rst  (rst),
        .load (shadow_load),
        .d    (cnt_in),
        .q    (shadow_q)
    );

    assign frozen = ctrl_freeze;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t         rd_state, rd_next;
    logic [ADDR_W-1:0] ar_addr;
    logic              ar_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= RD_AR;
        end else begin
            rd_state <= rd_next;
        end
    end

    always_comb begin
        rd_next       = rd_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (rd_state)
            RD_AR: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) rd_next = RD_SELECT;
            end
            RD_SELECT: rd_next = RD_R;
            RD_R: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) rd_next = RD_AR;
            end
            default: rd_next = RD_AR;
        endcase
    end

    assign ar_fire = s_axi_arvalid && s_axi_arready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_addr <= '0;
        end else if (ar_fire) begin
            ar_addr <= s_axi_araddr;
        end
    end

    // Counters are served from the shadow while frozen so a multi-word read
    // sees one coherent moment in time.
    logic [NUM_CNT*CNT_W-1:0] cnt_view;
    logic [ADDR_W-1:0]        cnt_off;
    logic [CNT_W-1:0]         cnt_sel;
    logic [31:0]              rd_data_nxt;
    logic [1:0]               rd_resp_nxt;

    assign cnt_view = ctrl_freeze ? shadow_q : cnt_in;
    assign cnt_off  = ar_addr - A_CNT_BASE;

    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (cnt_off[ADDR_W-1:2] == (ADDR_W-2)'(i)) cnt_sel = cnt_view[i*CNT_W +: CNT_W];
        end
    end

    always_comb begin
        rd_data_nxt = '0;
        rd_resp_nxt = RESP_OKAY;
        if (ar_addr[1:0] != 2'b00) begin
            rd_resp_nxt = RESP_SLVERR;
        end else if (ar_addr == A_ID) begin
            rd_data_nxt = ID_VALUE;
        end else if (ar_addr == A_CTRL) begin
            rd_data_nxt[CTRL_FREEZE_BIT] = ctrl_freeze;
        end else if (ar_addr == A_STATUS) begin
            rd_data_nxt = {11'd0, 5'(CNT_W - 1), 7'd0, ctrl_freeze, 8'(NUM_CNT)};
        end else if (ar_addr >= A_CNT_BASE && ar_addr < A_CNT_END) begin
            rd_data_nxt[CNT_W-1:0] = cnt_sel;
        end else begin
            rd_resp_nxt = RESP_SLVERR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (rd_state == RD_SELECT) begin
            s_axi_rdata <= rd_data_nxt;
            s_axi_rresp <= rd_resp_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t         wr_state, wr_next;
    logic              aw_held, w_held;
    logic [ADDR_W-1:0] aw_addr;
    logic [2:0]        w_data;
    logic              w_strb0;
    logic              aw_fire, w_fire;
    logic              wr_hit_ctrl, commit_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= WR_IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    // A channel captured earlier keeps its ready low until the commit, so
    // AW and W can arrive in either order or together.
    always_comb begin
        wr_next       = wr_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                s_axi_awready = !aw_held;
                s_axi_wready  = !w_held;
                if ((aw_held || s_axi_awvalid) && (w_held || s_axi_wvalid)) wr_next = WR_EXEC;
            end
            WR_EXEC: wr_next = WR_BRESP;
            WR_BRESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    assign aw_fire = s_axi_awvalid && s_axi_awready;
    assign w_fire  = s_axi_wvalid && s_axi_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb0 <= 1'b0;
        end else if (wr_state == WR_EXEC) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_addr <= s_axi_awaddr;
            end
            if (w_fire) begin
                w_held  <= 1'b1;
                w_data  <= s_axi_wdata[2:0];
                w_strb0 <= s_axi_wstrb[0];
            end
        end
    end

    // Only CTRL is writable; an exact match also rejects unaligned offsets.
    assign wr_hit_ctrl = (aw_addr == A_CTRL);
    assign commit_en   = (wr_state == WR_EXEC) && wr_hit_ctrl && w_strb0;

    // Entering freeze captures the counters so the frozen view starts from now.
    assign shadow_load = commit_en &&
                         (w_data[CTRL_SNAP_BIT] || (w_data[CTRL_FREEZE_BIT] && !ctrl_freeze));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_freeze <= 1'b0;
            cnt_clear   <= 1'b0;
            s_axi_bresp <= RESP_OKAY;
        end else begin
            cnt_clear <= commit_en && w_data[CTRL_CLEAR_BIT];
            if (commit_en) ctrl_freeze <= w_data[CTRL_FREEZE_BIT];
            if (wr_state == WR_EXEC) s_axi_bresp <= wr_hit_ctrl ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule

// File: tb/tb_eth_stats_axilite.sv
// tb/tb_eth_stats_axilite.sv - self-checking bench for eth_stats_axilite
module tb_eth_stats_axilite;

    localparam int          ADDR_W   = 14;
    localparam int          NUM_CNT  = 3;
    localparam int          CNT_W    = 32;
    localparam logic [31:0] ID_VALUE = 32'h00E7_0001;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     awvalid = 1'b0, awready;
    logic [ADDR_W-1:0]        awaddr  = '0;
    logic                     wvalid  = 1'b0, wready;
    logic [31:0]              wdata   = '0;
    logic [3:0]               wstrb   = '0;
    logic                     bvalid, bready = 1'b0;
    logic [1:0]               bresp;
    logic                     arvalid = 1'b0, arready;
    logic [ADDR_W-1:0]        araddr  = '0;
    logic                     rvalid, rready = 1'b0;
    logic [31:0]              rdata;
    logic [1:0]               rresp;
    logic [NUM_CNT*CNT_W-1:0] cnt_in = '0;
    logic                     cnt_clear, frozen;

    int checks     = 0;
    int failures   = 0;
    int clr_cycles = 0;

    // Reference state: live counter values, the frozen copy and the freeze flag.
    int unsigned live[NUM_CNT];
    int unsigned m_shadow[NUM_CNT];
    logic        m_freeze;

    eth_stats_axilite #(
        .ADDR_W   (ADDR_W),
        .NUM_CNT  (NUM_CNT),
        .CNT_W    (CNT_W),
        .ID_VALUE (ID_VALUE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (3'b000),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_bresp   (bresp),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (3'b000),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .cnt_in        (cnt_in),
        .cnt_clear     (cnt_clear),
        .frozen        (frozen)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cnt_clear) clr_cycles++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_cnt();
        for (int i = 0; i < NUM_CNT; i++) cnt_in[i*CNT_W +: CNT_W] = live[i];
    endtask

    // Expected read result from the register map rules.
    function automatic void model_read(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                                       output logic [1:0] r);
        int unsigned off = 32'(a);
        d = 32'd0;
        r = 2'b00;
        if (off % 4 != 0)       r = 2'b10;
        else if (off == 0)      d = ID_VALUE;
        else if (off == 4)      d = 32'(m_freeze);
        else if (off == 8)      d = 32'(NUM_CNT) | (32'(m_freeze) << 8) | (32'(CNT_W - 1) << 16);
        else if (off >= 12 && (off - 12) / 4 < NUM_CNT)
            d = m_freeze ? m_shadow[(off - 12) / 4] : live[(off - 12) / 4];
        else                    r = 2'b10;
    endfunction

    // Applies a write to the model; returns expected bresp and whether clear fires.
    function automatic logic [1:0] model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                                               input logic [3:0] s, output int clr);
        clr = 0;
        if (32'(a) != 4) return 2'b10;
        if (s[0]) begin
            if (d[1] || (d[0] && !m_freeze)) m_shadow = live;
            m_freeze = d[0];
            clr      = int'(d[2]);
        end
        return 2'b00;
    endfunction

    task automatic do_read(input logic [ADDR_W-1:0] a, input int hold,
                           output logic [31:0] d, output logic [1:0] r);
        int n;
        int lat;
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 arvalid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rvalid && lat < 50);
        chk("rd_latency", 32'(lat), 32'd2);
        d = rdata;
        r = rresp;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("r_hold_valid", 32'(rvalid), 32'd1);
            chk("r_hold_data", rdata, d);
            chk("r_hold_resp", 32'(rresp), 32'(r));
        end
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
    endtask

    // order: 0 = AW and W together, 1 = W first, 2 = AW first.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int order, input int hold, output logic [1:0] br);
        int n;
        @(negedge clk);
        if (order != 2) begin wdata = d; wstrb = s; wvalid = 1'b1; end
        if (order != 1) begin awaddr = a; awvalid = 1'b1; end
        if (order != 0) begin
            @(posedge clk);
            #1;
            if (order == 1) begin
                chk("w_captured_ready", 32'(wready), 32'd0);
                wvalid  = 1'b0;
                awaddr  = a;
                awvalid = 1'b1;
            end else begin
                chk("aw_captured_ready", 32'(awready), 32'd0);
                awvalid = 1'b0;
                wdata   = d;
                wstrb   = s;
                wvalid  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        chk("b_arrives", 32'(bvalid), 32'd1);
        br = bresp;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("b_hold_valid", 32'(bvalid), 32'd1);
            chk("b_hold_resp", 32'(bresp), 32'(br));
        end
        bready = 1'b1;
        @(posedge clk);
        #1 bready = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a);
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        model_read(a, ed, er);
        do_read(a, 0, d, r);
        chk({tag, "_data"}, d, ed);
        chk({tag, "_resp"}, 32'(r), 32'(er));
    endtask

    task automatic wr_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int order);
        logic [1:0] br, ebr;
        int         eclr, c0;
        c0  = clr_cycles;
        ebr = model_write(a, d, s, eclr);
        do_write(a, d, s, order, 0, br);
        @(negedge clk);
        chk({tag, "_bresp"}, 32'(br), 32'(ebr));
        chk({tag, "_clear_cycles"}, 32'(clr_cycles - c0), 32'(eclr));
        chk({tag, "_frozen"}, 32'(frozen), 32'(m_freeze));
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          n;

        m_freeze = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin live[i] = 0; m_shadow[i] = 0; end
        drive_cnt();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_cnt_clear", 32'(cnt_clear), 32'd0);
        chk("rst_frozen", 32'(frozen), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", 32'(arready), 32'd1);
        chk("post_rst_awready", 32'(awready), 32'd1);
        chk("post_rst_wready", 32'(wready), 32'd1);

        // ID and STATUS
        do_read(14'h0, 0, d, r);
        chk("id_data", d, ID_VALUE);
        chk("id_resp", 32'(r), 32'd0);
        do_read(14'h8, 0, d, r);
        chk("status_data", d, 32'h001F_0003);

        // Live counters and read errors
        live[0] = 10; live[1] = 20; live[2] = 30;
        drive_cnt();
        rd_chk("cnt0", 14'hC);
        rd_chk("cnt1", 14'h10);
        rd_chk("cnt2", 14'h14);
        do_read(14'h18, 0, d, r);
        chk("past_end_resp", 32'(r), 32'h2);
        chk("past_end_data", d, 32'd0);
        do_read(14'h2, 0, d, r);
        chk("unaligned_resp", 32'(r), 32'h2);
        chk("unaligned_data", d, 32'd0);

        // Freeze with W before AW, then release
        wr_chk("freeze_on", 14'h4, 32'h1, 4'hF, 1);
        live[0] = 99;
        drive_cnt();
        do_read(14'hC, 0, d, r);
        chk("frozen_cnt0", d, 32'd10);
        do_read(14'h8, 0, d, r);
        chk("status_freeze_bit", 32'(d[8]), 32'd1);
        chk("frozen_pin", 32'(frozen), 32'd1);
        wr_chk("freeze_off", 14'h4, 32'h0, 4'hF, 2);
        do_read(14'hC, 0, d, r);
        chk("live_cnt0", d, 32'd99);

        // Snapshot while frozen
        wr_chk("freeze_on2", 14'h4, 32'h1, 4'h1, 0);
        live[0] = 55;
        drive_cnt();
        wr_chk("snapshot", 14'h4, 32'h3, 4'h1, 0);
        do_read(14'hC, 0, d, r);
        chk("snap_cnt0", d, 32'd55);
        do_read(14'h4, 0, d, r);
        chk("ctrl_readback", d, 32'h1);

        // Clear pulse, strobe gating and write errors
        wr_chk("clear", 14'h4, 32'h4, 4'h1, 0);
        wr_chk("nostrb", 14'h4, 32'h5, 4'hE, 0);
        wr_chk("wr_id", 14'h0, 32'hDEAD_BEEF, 4'hF, 0);
        rd_chk("id_after_wr", 14'h0);
        wr_chk("wr_unaligned", 14'h5, 32'h1, 4'hF, 1);
        wr_chk("wr_unmapped", 14'h20, 32'h1, 4'hF, 2);
        rd_chk("ctrl_after_err", 14'h4);

        // Back-pressure: responses held stable
        do_read(14'h10, 5, d, r);
        do_write(14'h8, 32'h1, 4'hF, 0, 5, r);
        chk("ro_status_bresp", 32'(r), 32'h2);

        // Randomized traffic against the model
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < NUM_CNT; i++) if ($urandom_range(0, 1) == 1) live[i] = $urandom;
            drive_cnt();
            if ($urandom_range(0, 2) == 0) begin
                logic [ADDR_W-1:0] wa;
                wa = ($urandom_range(0, 3) != 0) ? 14'h4 : ADDR_W'($urandom_range(0, 31));
                wr_chk("rnd_wr", wa, 32'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                       int'($urandom_range(0, 2)));
            end else begin
                rd_chk("rnd_rd", ($urandom_range(0, 7) == 0) ? 14'h3FFC
                                                             : ADDR_W'($urandom_range(0, 35)));
            end
        end

        // Reset while a read response is pending
        wr_chk("pre_rst_freeze", 14'h4, 32'h1, 4'h1, 0);
        @(negedge clk);
        araddr  = 14'h0;
        arvalid = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_frozen", 32'(frozen), 32'd0);
        @(negedge clk);
        chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
        rst = 1'b0;
        m_freeze = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) m_shadow[i] = 0;
        rd_chk("ctrl_after_rst", 14'h4);
        rd_chk("cnt_after_rst", 14'hC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/eth_stats_axilite.md
Name: eth_stats_axilite

Overview:
Parametrised AXI4-Lite slave exposing NUM_CNT packet-statistics counters from the Ethernet RX/TX datapath, plus ID, status and control registers. Unlike the previous read-only debug slave, it adds a write channel, an atomic snapshot (freeze) of all counters and a counter-clear pulse to the datapath. Sits between the host AXI-Lite interconnect and the datapath counter outputs.

Parameters:
ADDR_W, 14, AXI-Lite address width.
NUM_CNT, 3, number of counter inputs (1..64).
CNT_W, 32, counter width (1..32); values are zero-extended to 32 bits on read.
ID_VALUE, 32'hE7_0001, constant returned by the ID register.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
s_axi_awvalid/awready  in/out  1  write address handshake
s_axi_awaddr  in  ADDR_W  write address
s_axi_awprot  in  3  ignored
s_axi_wvalid/wready  in/out  1  write data handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_bvalid/bready  out/in  1  write response handshake
s_axi_bresp  out  2  write response
s_axi_arvalid/arready  in/out  1  read address handshake
s_axi_araddr  in  ADDR_W  read address
s_axi_arprot  in  3  ignored
s_axi_rvalid/rready  out/in  1  read data handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
cnt_in  in  NUM_CNT*CNT_W  live counters; counter i = bits [i*CNT_W +: CNT_W]
cnt_clear  out  1  one-cycle pulse requesting the datapath to zero its counters
frozen  out  1  mirrors CTRL.freeze

Behaviour:
- Reset (async assert, sync release): read FSM=AR, write FSM=IDLE, CTRL=0, shadow bank=0, rvalid=bvalid=0, cnt_clear=0, rdata=0, rresp=bresp=0. arready=awready=wready=1 once rst deasserts.
- Address map (byte offsets, word aligned): 0x0 ID (RO), 0x4 CTRL (RW), 0x8 STATUS (RO: [7:0]=NUM_CNT, [8]=freeze, [15:9]=0, [20:16]=CNT_W-1, rest 0), 0xC+4*i counter i (RO), i<NUM_CNT.
- CTRL bits: [0] freeze (RW). [1] snapshot (write-1 action, reads 0). [2] clear (write-1 action, reads 0). Others read 0.
- Read FSM: AR -> SELECT on arvalid&&arready (address latched); SELECT -> R unconditionally, loading rdata/rresp; R -> AR on rready. Latency arvalid accept to rvalid = 2 cycles. rdata/rresp stable while rvalid&&!rready.
- Counter read value: shadow[i] when freeze=1, else cnt_in sampled in the SELECT cycle.
- Read errors: unaligned address (addr[1:0]!=0) or offset beyond the last counter -> rresp=2'b10 (SLVERR), rdata=0.
- Write FSM states: IDLE (awready=wready=1), AW and W accepted independently in either order or in the same cycle; a channel that is already captured deasserts its ready. Once both are held -> EXEC (1 cycle: commit), then BRESP (bvalid=1), then -> IDLE on bready.
- Commit, CTRL only: if wstrb[0], freeze<=wdata[0]; snapshot bit -> shadow[all]<=cnt_in in the same cycle; the shadow also loads when freeze transitions 0->1. Clear bit -> cnt_clear=1 for exactly the cycle after EXEC. bresp=OKAY.
- wstrb[0]=0 on CTRL -> no effect, bresp=OKAY.
- Write to an RO, unaligned or unmapped address -> no state change, bresp=SLVERR.
- Simultaneous read and write: the channels are fully independent. A read in SELECT during the same cycle as EXEC returns pre-commit values.
- Reset mid-transaction: both FSMs abort immediately, rvalid and bvalid drop, and no commit occurs.

Decomposition:
- Package eth_stats_pkg: read and write FSM enums, register offsets (ID, CTRL, STATUS, CNT_BASE), CTRL bit indices, AXI resp constants (OKAY=2'b00, SLVERR=2'b10).
- One sub-module, eth_stats_shadow: NUM_CNT x CNT_W register bank with a load strobe and async reset.

Test Plan:
- Reset, then read 0x0 -> rdata=ID_VALUE, rresp=0; read 0x8 with NUM_CNT=3, CNT_W=32 -> rdata=32'h001F_0003.
- cnt_in={32'd30,32'd20,32'd10}, freeze=0; read 0xC/0x10/0x14 -> 10/20/30 OKAY; read 0x18 and 0x2 -> SLVERR, rdata=0.
- Write CTRL=0x1 with W one cycle before AW; then change cnt_in[0] to 99 -> read 0xC returns 10, STATUS[8]=1, frozen=1; write CTRL=0x0 -> read returns 99.
- Freeze on, cnt_in[0]=55, write CTRL=0x3 -> read 0xC returns 55, read CTRL returns 0x1.
- Write CTRL=0x4 -> cnt_clear high exactly 1 cycle, bresp=OKAY; write 0x0 -> bresp=SLVERR, ID unchanged.
- Hold rready=0 and bready=0 for 5 cycles -> responses stable; assert rst during R -> rvalid=0 next edge, CTRL=0.
